// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-port bundle between the TX FIFO and the UART drain.
//   fifo_empty : FIFO empty flag (FIFO -> UART)
//   fifo_dout  : FIFO read data, valid the cycle after a pop edge (FIFO -> UART)
//   fifo_rd_en : pop request, one-cycle pulse (UART -> FIFO)
// The master modport is the UART side, which issues the pops.
interface uart_tx_fifo_drain_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a TX FIFO. It pops one word per frame and sends
// start, DATA_WIDTH data bits LSB-first, an optional parity bit and STOP_BITS
// stop bits on tx. All outputs are registered.
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high
//   fifo       : FIFO read port (master side: empty/dout in, rd_en out)
//   tx         : serial line, idles high
//   busy       : high in every state except idle
//   frame_done : one-cycle pulse when the last stop bit ends
module uart_tx_fifo_drain #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_tx_fifo_drain_if.master     fifo,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StLoad, StStart, StData, StParity, StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  acc_q, acc_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  baud_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      acc_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    tx_d      = tx_q;
    rd_en_d   = 1'b0;
    done_d    = 1'b0;
    baud_last = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    unique case (state_q)
      StIdle: begin
        if (!fifo.fifo_empty) begin
          state_d = StFetch;
          rd_en_d = 1'b1;
        end
      end
      // FIFO pops at the edge ending this cycle; data is readable in LOAD.
      StFetch: state_d = StLoad;
      StLoad: begin
        shift_d = fifo.fifo_dout;
        tx_d    = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        acc_d   = 1'b0;
        state_d = StStart;
      end
      StStart: begin
        if (baud_last) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          cnt_d   = '0;
          acc_d   = acc_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            idx_d = '0;
            if (PARITY != 0) begin
              // Odd parity is the complement of the running XOR.
              tx_d    = acc_q ^ shift_q[0] ^ (PARITY == 2);
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StParity: begin
        if (baud_last) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Bit index is reused to count stop bits.
      StStop: begin
        if (baud_last) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  assign fifo.fifo_rd_en = rd_en_q;
  assign tx              = tx_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three instances (8N1, 8E1, 8O2) at 10 clk/bit,
// each fed by a queue-like FIFO model; frames are checked cycle-by-cycle
// against a bit list built from the word, parity mode and stop count.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int par_cfg  [3] = '{0, 1, 2};
  int stop_cfg [3] = '{1, 1, 2};

  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) bus0 ();
  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) bus1 ();
  uart_tx_fifo_drain_if #(.DATA_WIDTH(8)) bus2 ();

  logic [2:0] tx_w, busy_w, done_w, rd_w;

  uart_tx_fifo_drain #(.CLK_FREQ(1000), .BAUD(100), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1))
    dut0 (.clk(clk), .reset(reset), .fifo(bus0), .tx(tx_w[0]), .busy(busy_w[0]),
          .frame_done(done_w[0]));
  uart_tx_fifo_drain #(.CLK_FREQ(1000), .BAUD(100), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1))
    dut1 (.clk(clk), .reset(reset), .fifo(bus1), .tx(tx_w[1]), .busy(busy_w[1]),
          .frame_done(done_w[1]));
  uart_tx_fifo_drain #(.CLK_FREQ(1000), .BAUD(100), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2))
    dut2 (.clk(clk), .reset(reset), .fifo(bus2), .tx(tx_w[2]), .busy(busy_w[2]),
          .frame_done(done_w[2]));

  assign rd_w = {bus2.fifo_rd_en, bus1.fifo_rd_en, bus0.fifo_rd_en};

  // FIFO models: circular store, write pointer owned by the stimulus process.
  logic [7:0] mem [3][32];
  int wp [3] = '{0, 0, 0};
  int rp [3] = '{0, 0, 0};
  logic [7:0] dout [3];

  assign bus0.fifo_empty = (wp[0] == rp[0]);
  assign bus1.fifo_empty = (wp[1] == rp[1]);
  assign bus2.fifo_empty = (wp[2] == rp[2]);
  assign bus0.fifo_dout  = dout[0];
  assign bus1.fifo_dout  = dout[1];
  assign bus2.fifo_dout  = dout[2];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i] && wp[i] != rp[i]) begin
        dout[i] <= mem[i][rp[i] % 32];
        rp[i]   <= rp[i] + 1;
      end
    end
  end

  // Pulse counters; each pulse is counted at the edge that ends it.
  int rd_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i] === 1'b1) rd_cnt[i] <= rd_cnt[i] + 1;
      if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  int   sel = 0;
  logic tx_m, busy_m, done_m;
  always_comb begin
    tx_m   = tx_w[sel];
    busy_m = busy_w[sel];
    done_m = done_w[sel];
  end

  task automatic push(input int i, input logic [7:0] w);
    mem[i][wp[i] % 32] = w;
    wp[i] = wp[i] + 1;
  endtask

  // Waits for the start bit of the selected instance, then checks the whole
  // frame. exp_wait is the number of negedges from the call to the first low tx.
  task automatic expect_frame(input logic [7:0] w, input int exp_wait);
    logic bits [$];
    int   waited;
    bit   bad_tx, bad_aux;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(w[i]);
    if (par_cfg[sel] != 0) bits.push_back((^w) ^ (par_cfg[sel] == 2));
    for (int s = 0; s < stop_cfg[sel]; s++) bits.push_back(1'b1);

    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx_m !== 1'b0 && waited < 300);
    checks++;
    if (tx_m !== 1'b0) begin
      errors++;
      $display("FAIL start_timeout inst=%0d word=%h tx=%b want 0", sel, w, tx_m);
      return;
    end
    checks++;
    if (waited != exp_wait) begin
      errors++;
      $display("FAIL start_latency inst=%0d word=%h got %0d want %0d", sel, w, waited,
               exp_wait);
    end

    bad_aux = 1'b0;
    for (int b = 0; b < bits.size(); b++) begin
      bad_tx = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (tx_m !== bits[b]) bad_tx = 1'b1;
        if (done_m !== 1'b0 || busy_m !== 1'b1) bad_aux = 1'b1;
      end
      checks++;
      if (bad_tx) begin
        errors++;
        $display("FAIL frame_bit inst=%0d word=%h bit=%0d got tx=%b want %b", sel, w, b,
                 tx_m, bits[b]);
      end
    end
    checks++;
    if (bad_aux) begin
      errors++;
      $display("FAIL frame_busy_done inst=%0d word=%h got busy/done deviation want 1/0",
               sel, w);
    end

    @(negedge clk);
    checks++;
    if (done_m !== 1'b1 || tx_m !== 1'b1 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL frame_end inst=%0d word=%h got done=%b tx=%b busy=%b want 1 1 0", sel,
               w, done_m, tx_m, busy_m);
    end
  endtask

  task automatic test_reset();
    bit bad;
    push(0, 8'h5A);
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx_w !== 3'b111 || rd_w !== 3'b000 || busy_w !== 3'b000 || done_w !== 3'b000)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_hold got tx=%b rd=%b busy=%b done=%b want 111 000 000 000", tx_w,
               rd_w, busy_w, done_w);
    end
    reset = 1'b0;
    sel = 0;
    expect_frame(8'h5A, 3);
  endtask

  task automatic test_basic_a5();
    int rd0, dn0;
    sel = 0;
    @(negedge clk);
    rd0 = rd_cnt[0];
    dn0 = done_cnt[0];
    push(0, 8'hA5);
    expect_frame(8'hA5, 3);
    @(negedge clk);
    checks++;
    if (rd_cnt[0] - rd0 != 1 || done_cnt[0] - dn0 != 1) begin
      errors++;
      $display("FAIL a5_pulses got rd=%0d done=%0d want 1 1", rd_cnt[0] - rd0,
               done_cnt[0] - dn0);
    end
  endtask

  task automatic test_parity_stop();
    for (int i = 1; i < 3; i++) begin
      sel = i;
      @(negedge clk);
      push(i, 8'hA5);
      expect_frame(8'hA5, 3);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h01, 8'h80, 8'hFF};
    int rd0, dn0;
    sel = 0;
    @(negedge clk);
    rd0 = rd_cnt[0];
    dn0 = done_cnt[0];
    for (int i = 0; i < 3; i++) push(0, words[i]);
    for (int i = 0; i < 3; i++) expect_frame(words[i], 3);
    @(negedge clk);
    checks++;
    if (rd_cnt[0] - rd0 != 3 || done_cnt[0] - dn0 != 3) begin
      errors++;
      $display("FAIL b2b_pulses got rd=%0d done=%0d want 3 3", rd_cnt[0] - rd0,
               done_cnt[0] - dn0);
    end
  endtask

  task automatic test_random();
    logic [7:0] words [4];
    for (int i = 0; i < 3; i++) begin
      sel = i;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        words[k] = 8'($urandom_range(0, 255));
        push(i, words[k]);
      end
      for (int k = 0; k < 4; k++) expect_frame(words[k], 3);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    int waited, dn0;
    sel = 0;
    @(negedge clk);
    dn0 = done_cnt[0];
    push(0, 8'h3C);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx_m !== 1'b0 && waited < 300);
    checks++;
    if (tx_m !== 1'b0) begin
      errors++;
      $display("FAIL mid_start tx=%b want 0", tx_m);
      return;
    end
    // Start bit plus data bits 0..2, then middle of data bit 3.
    repeat (4 * CPB + 4) @(negedge clk);
    checks++;
    if (tx_m !== 1'b1 || busy_m !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit3 got tx=%b busy=%b want 1 1", tx_m, busy_m);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_m !== 1'b1 || busy_m !== 1'b0 || rd_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got tx=%b busy=%b rd=%b want 1 0 0", tx_m, busy_m, rd_w[0]);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    w = 8'($urandom_range(0, 255));
    push(0, w);
    expect_frame(w, 3);
    @(negedge clk);
    checks++;
    if (done_cnt[0] - dn0 != 1) begin
      errors++;
      $display("FAIL mid_done_count got %0d want 1", done_cnt[0] - dn0);
    end
  endtask

  task automatic test_idle_empty();
    int rd0 [3], dn0 [3];
    bit bad;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rd0[i] = rd_cnt[i];
      dn0[i] = done_cnt[i];
    end
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (tx_w !== 3'b111 || rd_w !== 3'b000 || busy_w !== 3'b000) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_lines got tx=%b rd=%b busy=%b want 111 000 000", tx_w, rd_w,
               busy_w);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_cnt[i] != rd0[i] || done_cnt[i] != dn0[i]) begin
        errors++;
        $display("FAIL idle_pulses inst=%0d got rd=%0d done=%0d want 0 0", i,
                 rd_cnt[i] - rd0[i], done_cnt[i] - dn0[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_parity_stop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_idle_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
